// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit. Each normal op takes 32 radix-2 iterations.
// Divide-by-zero and signed overflow finish in one cycle with fixed results.
module muldiv_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] OPERAND_1,
    input  logic [31:0] OPERAND_2,
    input  logic        FLUSH,
    input  logic        HOLD,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op;
    logic [31:0] b_mag;
    logic [63:0] acc;
    logic        neg_res;
    logic        neg_rem;

    // Operand decode, done only while IDLE.
    logic        is_div;
    logic        op1_signed;
    logic        op2_signed;
    logic        s1;
    logic        s2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_result;

    assign is_div     = FUNC3[2];
    assign op1_signed = (FUNC3 == 3'b001) | (FUNC3 == 3'b010) | (FUNC3 == 3'b100) | (FUNC3 == 3'b110);
    assign op2_signed = (FUNC3 == 3'b001) | (FUNC3 == 3'b100) | (FUNC3 == 3'b110);
    assign s1         = op1_signed & OPERAND_1[31];
    assign s2         = op2_signed & OPERAND_2[31];
    assign mag1       = s1 ? (~OPERAND_1 + 32'd1) : OPERAND_1;
    assign mag2       = s2 ? (~OPERAND_2 + 32'd1) : OPERAND_2;
    assign div_zero   = is_div & (OPERAND_2 == 32'd0);
    assign div_ovf    = ((FUNC3 == 3'b100) | (FUNC3 == 3'b110)) &
                        (OPERAND_1 == 32'h8000_0000) & (OPERAND_2 == 32'hFFFF_FFFF);

    always_comb begin
        special_result = 32'd0;
        if (div_zero)
            special_result = FUNC3[1] ? OPERAND_1 : 32'hFFFF_FFFF;
        else
            special_result = FUNC3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [63:0] div_next;
    logic [63:0] acc_next;

    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b_mag : 32'd0)};
    assign mul_next = {mul_sum, acc[31:1]};
    assign rem_sh   = acc[63:31];
    assign diff     = rem_sh - {1'b0, b_mag};
    assign div_next = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                               : {diff[31:0],   acc[30:0], 1'b1};
    assign acc_next = op[2] ? div_next : mul_next;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] calc_result;

    assign prod = neg_res ? (~acc_next + 64'd1) : acc_next;
    assign quo  = neg_res ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    assign rem  = neg_rem ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];

    always_comb begin
        calc_result = 32'd0;
        case (op)
            3'b000:                 calc_result = prod[31:0];
            3'b001, 3'b010, 3'b011: calc_result = prod[63:32];
            3'b100, 3'b101:         calc_result = quo;
            default:                calc_result = rem;
        endcase
    end

    assign BUSY = ((state == IDLE) & START & ~FLUSH) | (state == CALC);
    assign DONE = (state == FIN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            op      <= 3'd0;
            b_mag   <= 32'd0;
            acc     <= 64'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            RESULT  <= 32'd0;
        end else if (FLUSH) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        op <= FUNC3;
                        if (div_zero | div_ovf) begin
                            RESULT <= special_result;
                            state  <= FIN;
                        end else begin
                            b_mag   <= is_div ? mag2 : mag1;
                            acc     <= {32'd0, (is_div ? mag1 : mag2)};
                            neg_res <= s1 ^ s2;
                            neg_rem <= s1;
                            cnt     <= 5'd0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        RESULT <= calc_result;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    if (!HOLD)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic RV32M model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic [31:0] exp_q[$];
    logic [31:0] last_result;
    int          n_checks = 0;
    int          n_pass   = 0;

    muldiv_seq dut (
        .CLK       (clk),
        .RESET     (reset),
        .START     (start),
        .FUNC3     (func3),
        .OPERAND_1 (op1),
        .OPERAND_2 (op2),
        .FLUSH     (flush),
        .HOLD      (hold),
        .BUSY      (busy),
        .DONE      (done),
        .RESULT    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [63:0] ua64;
        logic [63:0] ub64;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        p    = 64'd0;
        case (f)
            3'b000: begin p = sa * sb;     return p[31:0];  end
            3'b001: begin p = sa * sb;     return p[63:32]; end
            3'b010: begin p = sa * ub;     return p[63:32]; end
            3'b011: begin p = ua64 * ub64; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Issues one op in the current cycle and follows it through FIN back to IDLE.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, output logic [31:0] got);
        int          cycles;
        int          busy_cnt;
        int          lat_exp;
        logic        special;
        logic [31:0] held;
        special = (f[2] && b == 32'd0) ||
                  ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat_exp = special ? 1 : 33;
        exp_q.push_back(ref_model(f, a, b));
        start = 1'b1;
        func3 = f;
        op1   = a;
        op2   = b;
        #1 check("busy_issue", busy, 1);
        @(posedge clk); #1;
        start    = 1'b0;
        func3    = 3'($urandom);
        op1      = $urandom;
        op2      = $urandom;
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 64) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", cycles, lat_exp);
        check("busy_cycles", busy_cnt, lat_exp - 1);
        got = result;
        check("result", result, exp_q.pop_front());
        check("busy_fin", busy, 0);
        held = result;
        for (int i = 0; i < hold_n; i++) begin
            hold  = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            check("hold_done", done, 1);
            check("hold_result", result, held);
            check("hold_busy", busy, 0);
        end
        hold  = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_fin", done, 0);
        last_result = held;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t dir_vecs[$] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
        '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
        '{3'b101, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] b;
        int          saw_done;
        reset = 1'b1;
        start = 1'b0;
        func3 = 3'd0;
        op1   = 32'd0;
        op2   = 32'd0;
        flush = 1'b0;
        hold  = 1'b0;
        last_result = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);

        // Directed table; MUL goes through three HOLD cycles in FIN.
        foreach (dir_vecs[i]) begin
            do_op(dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b, (i == 0) ? 3 : 0, got);
            check("directed", got, dir_vecs[i].r);
        end

        // Flush in the middle of a DIV, then restart on the very next cycle.
        start = 1'b1; func3 = 3'b100; op1 = 32'd1000; op2 = 32'd7;
        @(posedge clk); #1;
        start    = 1'b0;
        saw_done = 0;
        repeat (9) begin
            if (done) saw_done++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_no_done_calc", saw_done, 0);
        check("flush_done", done, 0);
        check("flush_busy", busy, 0);
        check("flush_result_kept", result, last_result);
        do_op(3'b100, 32'hFFFF_FC18, 32'd7, 0, got);

        // FLUSH beats START in IDLE.
        start = 1'b1; flush = 1'b1; func3 = 3'b000; op1 = 32'd3; op2 = 32'd5;
        #1 check("flush_beats_start_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start_idle", busy, 0);

        // Reset mid-CALC abandons the op.
        start = 1'b1; func3 = 3'b000; op1 = 32'd123; op2 = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_result", result, 0);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("midreset_no_done", saw_done, 0);

        // Random ops, with occasional special-case operands and HOLD.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = $urandom_range(0, 3);
                default: ;
            endcase
            do_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
